// File: rtl/serial_word_feeder_pkg.sv
// Shared constants for the serial word feeder: FSM state encoding and counter widths.
package serial_word_feeder_pkg;

  // FSM state encoding, kept as plain constants so older tools can consume it.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Default word width and the bit counter width that goes with it.
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Gap counter width; covers forced gaps of 0..15 idle cycles.
  localparam int GAP_W = 4;

  // Bit counter width for an arbitrary word width (never narrower than 1 bit).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_slot.sv
// One-entry holding slot: stores a word while the current word is still shifting.
module ser_hold_slot
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  // Capture a word on load; drop the full flag when the word is taken or flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data register is reset as well as the flag, so the slot never
      // presents X on data_out even though only full_q gates its use.
      data_q <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= data_in;
      full_q <= 1'b1;
    end else if (take || clear) begin
      full_q <= 1'b0;
    end
  end

  assign data_out = data_q;
  assign full     = full_q;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and shifts them out
// one bit per clock, with a one-word holding slot for back-to-back streaming.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy,
  output logic [7:0]       word_cnt
);

  localparam int               BCW      = cnt_width(WIDTH);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [BCW-1:0]   BIT_ONE  = BCW'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]       word_cnt_q, word_cnt_d;

  logic [WIDTH-1:0] shreg_adv;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full;
  logic             slot_load;
  logic             slot_take;
  logic             accept;

  // Ready depends only on the slot flag, never on din_valid.
  assign din_ready = ~hold_full;
  assign accept    = din_valid & din_ready;

  ser_hold_slot #(
    .WIDTH (WIDTH)
  ) u_hold_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (slot_load),
    .take     (slot_take),
    .clear    (1'b0),
    .data_in  (din),
    .data_out (hold_data),
    .full     (hold_full)
  );

  // Shift register advanced by one bit in the configured direction, zero-filled.
  always_comb begin
    if (MSB_FIRST) shreg_adv = {shreg_q[WIDTH-2:0], 1'b0};
    else           shreg_adv = {1'b0, shreg_q[WIDTH-1:1]};
  end

  // Next-state logic: word loading, shifting, gap timing and slot steering.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    word_cnt_d = word_cnt_q;
    slot_load  = 1'b0;
    slot_take  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // The slot is always empty here; an accepted word goes straight to shreg.
        if (accept) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shreg_d   = shreg_adv;
        bit_cnt_d = bit_cnt_q + BIT_ONE;
        if (bit_cnt_q == LAST_BIT) begin
          word_cnt_d = word_cnt_q + 8'd1;
          bit_cnt_d  = '0;
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
            slot_load = accept;
          end else if (hold_full) begin
            shreg_d   = hold_data;
            slot_take = 1'b1;
          end else if (accept) begin
            // Gapless hand-off: the word arriving on the last bit is loaded directly.
            shreg_d = din;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          slot_load = accept;
        end
      end

      ST_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_ONE;
        if (gap_cnt_q == GAP_ONE) begin
          bit_cnt_d = '0;
          if (hold_full) begin
            shreg_d   = hold_data;
            slot_take = 1'b1;
            state_d   = ST_SHIFT;
          end else if (accept) begin
            shreg_d = din;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          slot_load = accept;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // pre-edge values, independent of statement order.
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Outputs decoded from registered state only.
  assign bit_valid   = (state_q == ST_SHIFT);
  assign frame_start = bit_valid & (bit_cnt_q == '0);
  assign ser_out     = bit_valid & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign busy        = (state_q != ST_IDLE) | hold_full;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Self-checking bench for serial_word_feeder: three instances (MSB-first gapless,
// LSB-first gapless, MSB-first with GAP=2), a bit scoreboard per instance and
// directed timing checks.
module tb_serial_word_feeder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din [3];
  logic         v   [3];
  logic         r   [3];
  logic         so  [3];
  logic         bv  [3];
  logic         fs  [3];
  logic         bsy [3];
  logic [7:0]   wc  [3];

  int total = 0;
  int bad   = 0;

  // Expected {frame_start, ser_out} per emitted bit, one queue per instance.
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] q_c[$];

  always #5 clk = ~clk;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(0)) u_a (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(v[0]), .din_ready(r[0]),
    .ser_out(so[0]), .bit_valid(bv[0]), .frame_start(fs[0]), .busy(bsy[0]), .word_cnt(wc[0]));

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP(0)) u_b (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(v[1]), .din_ready(r[1]),
    .ser_out(so[1]), .bit_valid(bv[1]), .frame_start(fs[1]), .busy(bsy[1]), .word_cnt(wc[1]));

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP(2)) u_c (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(v[2]), .din_ready(r[2]),
    .ser_out(so[2]), .bit_valid(bv[2]), .frame_start(fs[2]), .busy(bsy[2]), .word_cnt(wc[2]));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_all();
    q_a.delete();
    q_b.delete();
    q_c.delete();
  endtask

  // Present a word and hold it valid until accepted (bounded wait).
  task automatic send(input int id, input logic [W-1:0] w);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    din[id] = w;
    v[id]   = 1'b1;
    while (!acc && n < 20) begin
      acc = r[id];
      tick();
      n++;
    end
    if (!acc) chk1($sformatf("d%0d_send_timeout", id), acc, 1'b1);
    v[id] = 1'b0;
  endtask

  task automatic check_idle(input int id, input logic [7:0] exp_wc);
    chk1($sformatf("d%0d_idle_bv", id), bv[id], 1'b0);
    chk1($sformatf("d%0d_idle_so", id), so[id], 1'b0);
    chk1($sformatf("d%0d_idle_fs", id), fs[id], 1'b0);
    chk1($sformatf("d%0d_idle_ready", id), r[id], 1'b1);
    chk1($sformatf("d%0d_idle_busy", id), bsy[id], 1'b0);
    chk8($sformatf("d%0d_idle_wc", id), wc[id], exp_wc);
  endtask

  // Scoreboard push: on every accept, queue the word's bits in emission order.
  task automatic push_word(input int id, input logic [W-1:0] w);
    logic [1:0] item;
    int         b;
    for (int i = 0; i < W; i++) begin
      b    = (id == 1) ? i : (W - 1 - i);
      item = {(i == 0), w[b]};
      case (id)
        0:       q_a.push_back(item);
        1:       q_b.push_back(item);
        default: q_c.push_back(item);
      endcase
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int id = 0; id < 3; id++) begin
        if (v[id] && r[id]) push_word(id, din[id]);
      end
    end
  end

  // Scoreboard pop: every valid bit must match the next queued bit.
  task automatic mon_one(input int id);
    logic [1:0] e;
    int         sz;
    case (id)
      0:       sz = q_a.size();
      1:       sz = q_b.size();
      default: sz = q_c.size();
    endcase
    if (bv[id]) begin
      if (sz == 0) begin
        chk8($sformatf("d%0d_sb_underflow", id), 8'(sz), 8'd1);
      end else begin
        case (id)
          0:       e = q_a.pop_front();
          1:       e = q_b.pop_front();
          default: e = q_c.pop_front();
        endcase
        chk1($sformatf("d%0d_sb_bit", id), so[id], e[0]);
        chk1($sformatf("d%0d_sb_frame", id), fs[id], e[1]);
      end
    end else begin
      chk1($sformatf("d%0d_gate_so", id), so[id], 1'b0);
      chk1($sformatf("d%0d_gate_fs", id), fs[id], 1'b0);
    end
  endtask

  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) mon_one(id);
  end

  initial begin
    logic [10:0] gap_pat;
    for (int id = 0; id < 3; id++) begin
      din[id] = '0;
      v[id]   = 1'b0;
    end

    // Reset state on all instances.
    rst = 1'b0;
    tick();
    tick();
    for (int id = 0; id < 3; id++) check_idle(id, 8'd0);
    rst = 1'b1;
    tick();

    // Single MSB-first word 1100: bits 1,1,0,0, frame_start only on the first.
    send(0, 4'b1100);
    chk1("t1_bit0", so[0], 1'b1);
    chk1("t1_fs0", fs[0], 1'b1);
    tick();
    chk1("t1_bit1", so[0], 1'b1);
    chk1("t1_fs1", fs[0], 1'b0);
    tick();
    chk1("t1_bit2", so[0], 1'b0);
    tick();
    chk1("t1_bit3", so[0], 1'b0);
    chk1("t1_bv3", bv[0], 1'b1);
    tick();
    check_idle(0, 8'd1);

    // Back-to-back via the slot: 1100 then 0011, 8 contiguous bits.
    send(0, 4'b1100);
    send(0, 4'b0011);
    chk1("t2_ready_full", r[0], 1'b0);
    chk1("t2_busy", bsy[0], 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1($sformatf("t2_bv_%0d", i), bv[0], 1'b1);
      chk1($sformatf("t2_ready_%0d", i), r[0], (i >= 2));
      if (i == 2) chk1("t2_fs_second", fs[0], 1'b1);
    end
    tick();
    check_idle(0, 8'd3);

    // Stream of three words 1100,1100,1111: 12 contiguous bits.
    send(0, 4'b1100);
    send(0, 4'b1100);
    send(0, 4'b1111);
    chk1("t6_bv_start", bv[0], 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1($sformatf("t6_bv_%0d", i), bv[0], 1'b1);
    end
    tick();
    check_idle(0, 8'd6);

    // Accept exactly on the last-bit edge with an empty slot: direct, gapless load.
    send(0, 4'b1010);
    tick();
    tick();
    tick();
    din[0] = 4'b0110;
    v[0]   = 1'b1;
    chk1("lb_ready", r[0], 1'b1);
    tick();
    v[0] = 1'b0;
    din[0] = 4'b1111;
    chk1("lb_bv", bv[0], 1'b1);
    chk1("lb_fs", fs[0], 1'b1);
    chk1("lb_bit0", so[0], 1'b0);
    chk1("lb_slot_empty", r[0], 1'b1);
    chk8("lb_wc", wc[0], 8'd7);
    tick();
    chk1("lb_bit1_ignores_din", so[0], 1'b1);
    tick();
    tick();
    tick();
    check_idle(0, 8'd8);

    // LSB-first word 0001: bits 1,0,0,0.
    send(1, 4'b0001);
    chk1("t3_bit0", so[1], 1'b1);
    tick();
    chk1("t3_bit1", so[1], 1'b0);
    tick();
    tick();
    tick();
    check_idle(1, 8'd1);

    // GAP=2: two 1111 words separated by two idle cycles, then a trailing gap.
    gap_pat = 11'b11001111000;
    send(2, 4'b1111);
    send(2, 4'b1111);
    for (int i = 0; i < 11; i++) begin
      tick();
      chk1($sformatf("t4_bv_%0d", i), bv[2], gap_pat[10-i]);
      chk1($sformatf("t4_busy_%0d", i), bsy[2], (i < 10));
      if (!gap_pat[10-i]) chk1($sformatf("t4_so_%0d", i), so[2], 1'b0);
      if (i == 4) chk1("t4_fs_second", fs[2], 1'b1);
    end
    check_idle(2, 8'd2);

    // Reset mid-word after two bits: outputs clear immediately, without a clock.
    send(0, 4'b1100);
    tick();
    rst = 1'b0;
    flush_all();
    #2;
    chk1("t5_so", so[0], 1'b0);
    chk1("t5_bv", bv[0], 1'b0);
    chk1("t5_fs", fs[0], 1'b0);
    chk1("t5_ready", r[0], 1'b1);
    chk1("t5_busy", bsy[0], 1'b0);
    chk8("t5_wc", wc[0], 8'd0);
    tick();
    rst = 1'b1;
    tick();
    send(0, 4'b0101);
    chk1("t5_restart_fs", fs[0], 1'b1);
    chk1("t5_restart_bit0", so[0], 1'b0);
    tick();
    tick();
    tick();
    tick();
    check_idle(0, 8'd1);

    // Every queued bit must have been emitted.
    tick();
    chk8("drain_a", 8'(q_a.size()), 8'd0);
    chk8("drain_b", 8'(q_b.size()), 8'd0);
    chk8("drain_c", 8'(q_c.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
